// File: rtl/tc_pl_cap_gain_arb.sv
// tc_pl_cap_gain_arb: shares the capture-gain DAC write path between the host
// register bank (port 0) and the auto-gain calibration sweeper (port 1).
// Each port latches its latest request; a round-robin grant launches one
// dual-channel word pair at a time, waits for the DAC controller to finish,
// holds off for the analog settle time and reports done/timeout to the owner.
module tc_pl_cap_gain_arb #(
    parameter int CAP0_12     = 32,
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_en,
    input  logic [CAP0_12-1:0] req0_dacA,
    input  logic [CAP0_12-1:0] req0_dacB,
    output logic               req0_done,
    output logic               req0_err,
    input  logic               req1_en,
    input  logic [CAP0_12-1:0] req1_dacA,
    input  logic [CAP0_12-1:0] req1_dacB,
    output logic               req1_done,
    output logic               req1_err,
    output logic               gset_en,
    output logic [CAP0_12-1:0] gset_dacA,
    output logic [CAP0_12-1:0] gset_dacB,
    input  logic               gset_adc_cmpt,
    output logic               gain_busy,
    output logic               gain_owner,
    output logic               gain_timeout
);

    localparam int NPORT   = 2;
    // One shared counter serves both the completion timeout and the settle delay.
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_CMPT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // Where a completion leads: skip SETTLE entirely when no settle is wanted.
    localparam state_t CMPT_NEXT = (SETTLE_CYC == 0) ? ST_DONE : ST_SETTLE;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               err_reg;
    logic               err_next;
    logic               timeout_reg;
    logic               timeout_next;
    logic               last_reg;
    logic               owner_reg;
    logic [CAP0_12-1:0] dac_a_reg;
    logic [CAP0_12-1:0] dac_b_reg;

    logic [NPORT-1:0]   req_en;
    logic [CAP0_12-1:0] req_a [NPORT];
    logic [CAP0_12-1:0] req_b [NPORT];
    logic [NPORT-1:0]   pend;
    logic [CAP0_12-1:0] buf_a [NPORT];
    logic [CAP0_12-1:0] buf_b [NPORT];

    logic               grant_vld;
    logic               grant_port;

    assign req_en   = {req1_en, req0_en};
    assign req_a[0] = req0_dacA;
    assign req_a[1] = req1_dacA;
    assign req_b[0] = req0_dacB;
    assign req_b[1] = req1_dacB;

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            logic               pend_reg;
            logic [CAP0_12-1:0] buf_a_reg;
            logic [CAP0_12-1:0] buf_b_reg;

            // Request latch: newest words win; a pulse coinciding with this
            // port's grant re-arms pend so the new words get their own launch.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    pend_reg  <= 1'b0;
                    buf_a_reg <= '0;
                    buf_b_reg <= '0;
                end else if (req_en[gi]) begin
                    pend_reg  <= 1'b1;
                    buf_a_reg <= req_a[gi];
                    buf_b_reg <= req_b[gi];
                end else if (grant_vld && (grant_port == 1'(gi))) begin
                    pend_reg  <= 1'b0;
                end
            end

            assign pend[gi]  = pend_reg;
            assign buf_a[gi] = buf_a_reg;
            assign buf_b[gi] = buf_b_reg;
        end
    endgenerate

    // Round-robin grant: a lone pending port wins, a tie goes to the port that
    // did not win last time.
    always_comb begin
        grant_vld  = (state_reg == ST_IDLE) && (pend != '0);
        grant_port = 1'b0;
        if (pend == 2'b11) begin
            grant_port = ~last_reg;
        end else begin
            grant_port = pend[1];
        end
    end

    // State, counter and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            timeout_reg <= timeout_next;
        end
    end

    // Grant datapath: words are copied once at grant so they stay stable for
    // the whole transaction regardless of later requests.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            dac_a_reg <= '0;
            dac_b_reg <= '0;
        end else if (grant_vld) begin
            last_reg  <= grant_port;
            owner_reg <= grant_port;
            dac_a_reg <= buf_a[grant_port];
            dac_b_reg <= buf_b[grant_port];
        end
    end

    // Next-state logic; the counter only advances below its terminal value.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (grant_vld) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_next = '0;
                if (gset_adc_cmpt) begin
                    state_next = CMPT_NEXT;
                end else begin
                    state_next = ST_WAIT_CMPT;
                end
            end
            ST_WAIT_CMPT: begin
                if (gset_adc_cmpt) begin
                    state_next = CMPT_NEXT;
                    cnt_next   = '0;
                end else if (cnt_reg >= TIMEOUT_LAST) begin
                    state_next   = ST_DONE;
                    err_next     = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_reg >= SETTLE_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                err_next   = 1'b0;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Completion reporting goes to whichever port owns the transaction.
    always_comb begin
        req0_done = 1'b0;
        req0_err  = 1'b0;
        req1_done = 1'b0;
        req1_err  = 1'b0;
        if (state_reg == ST_DONE) begin
            if (owner_reg) begin
                req1_done = 1'b1;
                req1_err  = err_reg;
            end else begin
                req0_done = 1'b1;
                req0_err  = err_reg;
            end
        end
    end

    assign gset_en      = (state_reg == ST_LAUNCH);
    assign gset_dacA    = dac_a_reg;
    assign gset_dacB    = dac_b_reg;
    assign gain_busy    = (state_reg != ST_IDLE);
    assign gain_owner   = owner_reg;
    assign gain_timeout = timeout_reg;

endmodule

// File: tb/tb_tc_pl_cap_gain_arb.sv
// tb_tc_pl_cap_gain_arb: scoreboard bench for the capture-gain DAC arbiter.
// The driver predicts each launch (port, words, responder delay) from the
// round-robin / latest-wins rules and queues it; a monitor pops and checks
// on every gset_en and on every done pulse.
module tb_tc_pl_cap_gain_arb;
    localparam int W      = 32;
    localparam int SETTLE = 4;
    localparam int TMO    = 8;
    localparam int NORESP = 99;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_en = 1'b0, req1_en = 1'b0;
    logic [W-1:0] req0_dacA = '0, req0_dacB = '0, req1_dacA = '0, req1_dacB = '0;
    logic         req0_done, req0_err, req1_done, req1_err;
    logic         gset_en, gain_busy, gain_owner, gain_timeout;
    logic [W-1:0] gset_dacA, gset_dacB;
    logic         gset_adc_cmpt;

    // Second instance with no settle delay.
    logic         z_req0_en = 1'b0, z_req1_en = 1'b0, z_cmpt = 1'b0;
    logic [W-1:0] z_req0_dacA = '0, z_req0_dacB = '0, z_req1_dacA = '0, z_req1_dacB = '0;
    logic         z_req0_done, z_req0_err, z_req1_done, z_req1_err;
    logic         z_gset_en, z_busy, z_owner, z_timeout;
    logic [W-1:0] z_gset_dacA, z_gset_dacB;

    always #5 clk = ~clk;

    tc_pl_cap_gain_arb #(.CAP0_12(W), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_en(req0_en), .req0_dacA(req0_dacA), .req0_dacB(req0_dacB),
        .req0_done(req0_done), .req0_err(req0_err),
        .req1_en(req1_en), .req1_dacA(req1_dacA), .req1_dacB(req1_dacB),
        .req1_done(req1_done), .req1_err(req1_err),
        .gset_en(gset_en), .gset_dacA(gset_dacA), .gset_dacB(gset_dacB),
        .gset_adc_cmpt(gset_adc_cmpt),
        .gain_busy(gain_busy), .gain_owner(gain_owner), .gain_timeout(gain_timeout)
    );

    tc_pl_cap_gain_arb #(.CAP0_12(W), .SETTLE_CYC(0), .TIMEOUT_CYC(TMO)) dut_z (
        .clk(clk), .rst(rst),
        .req0_en(z_req0_en), .req0_dacA(z_req0_dacA), .req0_dacB(z_req0_dacB),
        .req0_done(z_req0_done), .req0_err(z_req0_err),
        .req1_en(z_req1_en), .req1_dacA(z_req1_dacA), .req1_dacB(z_req1_dacB),
        .req1_done(z_req1_done), .req1_err(z_req1_err),
        .gset_en(z_gset_en), .gset_dacA(z_gset_dacA), .gset_dacB(z_gset_dacB),
        .gset_adc_cmpt(z_cmpt),
        .gain_busy(z_busy), .gain_owner(z_owner), .gain_timeout(z_timeout)
    );

    typedef struct {
        int           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           d;          // cycles from launch to cmpt, NORESP = never
        bit           from_idle;  // launch follows request directly from idle
        int           req_cyc;
    } exp_t;

    exp_t launch_q[$];
    int   resp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lw = 1;             // model of last round-robin winner
    bit   sticky = 1'b0;      // model of gain_timeout
    bit   inflight = 1'b0;
    exp_t cur;
    int   cur_l = 0;
    int   last_done_cyc = -100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected/missing event, expected the opposite (cycle %0d)", name, cyc);
    endtask

    function automatic int rand_d();
        int d;
        d = $urandom_range(0, 10);
        return (d > TMO) ? NORESP : d;
    endfunction

    // Cycle counter: value seen at a negedge is the index of the current cycle.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder model of the DAC controller.
    initial begin
        int d;
        gset_adc_cmpt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && gset_en) begin
                if (resp_q.size() != 0) d = resp_q.pop_front();
                else d = NORESP;
                if (d != NORESP) begin
                    repeat (d) @(negedge clk);
                    gset_adc_cmpt = 1'b1;
                    @(negedge clk);
                    gset_adc_cmpt = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations on launches and checks done pulses.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (gset_en) begin
                if (inflight) fail("launch_while_busy");
                if (launch_q.size() == 0) begin
                    fail("unexpected_launch");
                end else begin
                    cur = launch_q.pop_front();
                    chk("launch_owner", gain_owner, cur.port);
                    chk("launch_busy", gain_busy, 1);
                    chk("launch_dacA", gset_dacA, cur.a);
                    chk("launch_dacB", gset_dacB, cur.b);
                    chk("launch_cycle", cyc, cur.from_idle ? cur.req_cyc + 2 : last_done_cyc + 2);
                    inflight = 1'b1;
                    cur_l = cyc;
                end
            end
            if (req0_done || req1_done) begin
                if (!inflight) begin
                    fail("unexpected_done");
                end else begin
                    chk("done_port", {req1_done, req0_done}, (cur.port != 0) ? 2 : 1);
                    chk("done_err", req0_err | req1_err, cur.d == NORESP);
                    chk("done_cycle", cyc,
                        (cur.d == NORESP) ? cur_l + 1 + TMO : cur_l + cur.d + 1 + SETTLE);
                    chk("held_dacA", gset_dacA, cur.a);
                    chk("held_dacB", gset_dacB, cur.b);
                    if (cur.d == NORESP) sticky = 1'b1;
                    chk("timeout_flag", gain_timeout, sticky);
                    inflight = 1'b0;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic push(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int d, input bit from_idle);
        exp_t e;
        e.port = p; e.a = a; e.b = b; e.d = d; e.from_idle = from_idle; e.req_cyc = cyc;
        launch_q.push_back(e);
        resp_q.push_back(d);
        lw = p;
        $display("txn: port %0d A=%08h B=%08h resp=%0d", p, a, b, d);
    endtask

    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin req0_en = 1'b1; req0_dacA = a; req0_dacB = b; end
        else begin req1_en = 1'b1; req1_dacA = a; req1_dacB = b; end
        @(negedge clk);
        req0_en = 1'b0;
        req1_en = 1'b0;
    endtask

    task automatic issue2(input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1);
        req0_en = 1'b1; req0_dacA = a0; req0_dacB = b0;
        req1_en = 1'b1; req1_dacA = a1; req1_dacB = b1;
        @(negedge clk);
        req0_en = 1'b0;
        req1_en = 1'b0;
    endtask

    task automatic wait_launch();
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = gset_en;
        end
        if (!seen) fail("launch_wait_expired");
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((launch_q.size() != 0 || inflight) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) fail("round_wait_expired");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, gain_busy, 0);
        chk({tag, "_gset_en"}, gset_en, 0);
        chk({tag, "_dacA"}, gset_dacA, 0);
        chk({tag, "_dacB"}, gset_dacB, 0);
        chk({tag, "_owner"}, gain_owner, 0);
        chk({tag, "_timeout"}, gain_timeout, 0);
        chk({tag, "_dones"}, {req1_done, req0_done, req1_err, req0_err}, 0);
    endtask

    task automatic round(input int mode);
        logic [W-1:0] a0, b0, a1, b1, a2, b2;
        int p, first;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        case (mode)
            0: begin
                p = $urandom_range(0, 1);
                push(p, a0, b0, rand_d(), 1'b1);
                issue(p, a0, b0);
            end
            1: begin
                first = 1 - lw;
                push(first, first ? a1 : a0, first ? b1 : b0, rand_d(), 1'b1);
                push(1 - first, first ? a0 : a1, first ? b0 : b1, rand_d(), 1'b0);
                issue2(a0, b0, a1, b1);
            end
            2: begin
                push(0, a0, b0, rand_d(), 1'b1);
                issue(0, a0, b0);
                wait_launch();
                push(1, a2, b2, rand_d(), 1'b0);
                issue(1, a1, b1);
                issue(1, a2, b2);
            end
            default: begin
                p = $urandom_range(0, 1);
                push(p, a0, b0, rand_d(), 1'b1);
                issue(p, a0, b0);
                wait_launch();
                push(p, a1, b1, rand_d(), 1'b0);
                issue(p, a1, b1);
            end
        endcase
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] wa;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Both at once from reset: port 0 first, then port 1.
        push(0, 32'h0000_0A0A, 32'h0000_0B0B, 3, 1'b1);
        push(1, 32'h0000_1A1A, 32'h0000_1B1B, 1, 1'b0);
        issue2(32'h0000_0A0A, 32'h0000_0B0B, 32'h0000_1A1A, 32'h0000_1B1B);
        wait_idle();

        // Single host write, cmpt at t+10 -> done at t+15.
        push(0, 32'h0000_1234, 32'h0000_ABCD, 8, 1'b1);
        issue(0, 32'h0000_1234, 32'h0000_ABCD);
        wait_idle();

        // Both pending after a port-0 grant: port 1 goes first.
        push(1, 32'h0000_2A2A, 32'h0000_2B2B, 2, 1'b1);
        push(0, 32'h0000_3A3A, 32'h0000_3B3B, 0, 1'b0);
        issue2(32'h0000_3A3A, 32'h0000_3B3B, 32'h0000_2A2A, 32'h0000_2B2B);
        wait_idle();

        // Overwrite on port 1 while port 0 is busy.
        push(0, 32'h0000_5555, 32'h0000_6666, 4, 1'b1);
        issue(0, 32'h0000_5555, 32'h0000_6666);
        wait_launch();
        push(1, 32'h0000_0020, 32'h0000_0020, 1, 1'b0);
        issue(1, 32'h0000_0010, 32'h0000_0010);
        issue(1, 32'h0000_0020, 32'h0000_0020);
        wait_idle();

        // Timeout with no completion; flag stays set afterwards.
        push(0, 32'h0000_7777, 32'h0000_8888, NORESP, 1'b1);
        issue(0, 32'h0000_7777, 32'h0000_8888);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("timeout_sticky_idle", gain_timeout, 1);

        // Reset while settling: everything clears, no done pulse.
        wa = $urandom;
        push(0, wa, ~wa, 0, 1'b1);
        issue(0, wa, ~wa);
        wait_launch();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        launch_q.delete();
        resp_q.delete();
        inflight = 1'b0;
        sticky = 1'b0;
        lw = 1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_busy", gain_busy, 0);
        push(0, 32'h0000_CAFE, 32'h0000_F00D, 5, 1'b1);
        issue(0, 32'h0000_CAFE, 32'h0000_F00D);
        wait_idle();

        // Randomized rounds.
        for (int r = 0; r < 40; r++) round($urandom_range(0, 3));

        // Zero-settle instance: cmpt in the LAUNCH cycle -> DONE next cycle.
        z_req0_dacA = 32'h0000_4321;
        z_req0_dacB = 32'h0000_8765;
        z_req0_en = 1'b1;
        @(negedge clk);
        z_req0_en = 1'b0;
        @(negedge clk);
        chk("z_launch", z_gset_en, 1);
        chk("z_dacA", z_gset_dacA, 32'h0000_4321);
        chk("z_dacB", z_gset_dacB, 32'h0000_8765);
        z_cmpt = 1'b1;
        @(negedge clk);
        z_cmpt = 1'b0;
        chk("z_done", {z_req1_done, z_req0_done}, 2'b01);
        chk("z_err", z_req0_err, 0);
        @(negedge clk);
        chk("z_done_once", z_req0_done, 0);
        chk("z_idle", z_busy, 0);
        $display("txn: zero-settle port 0 launch/done checked");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tc_pl_cap_gain_arb.md
# tc_pl_cap_gain_arb

Round-robin arbiter and sequencer that shares the capture-gain DAC write path between two requesters: host register writes (port 0) and the auto-gain calibration sweeper (port 1). It latches each request, hands one dual-channel DAC word pair at a time to the gain DAC controller through the `gset_en`/`gset_adc_cmpt` handshake, and enforces an analog settle delay after each write. It reports completion or timeout back to the owning requester. It sits between the PS register bank / calibration logic and the gain-DAC SPI block.

## Interface
- `CAP0_12`, 32, width of each DAC channel word.
- `SETTLE_CYC`, 1000, clk cycles to wait after `gset_adc_cmpt` before reporting done; 0 means no settle.
- `TIMEOUT_CYC`, 65535, maximum clk cycles spent waiting for `gset_adc_cmpt`; must be ≥1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `req0_en`  in  1  one-cycle request pulse, host.
- `req0_dacA`, `req0_dacB`  in  CAP0_12  host words, sampled with `req0_en`.
- `req0_done`  out  1  one-cycle completion pulse.
- `req0_err`  out  1  high with `req0_done` when the write timed out.
- `req1_en`, `req1_dacA`, `req1_dacB`, `req1_done`, `req1_err`: same as the port-0 signals, for the calibration sweeper.
- `gset_en`  out  1  one-cycle launch pulse to the DAC controller.
- `gset_dacA`, `gset_dacB`  out  CAP0_12  registered words; stable from launch until done.
- `gset_adc_cmpt`  in  1  completion pulse from the DAC controller.
- `gain_busy`  out  1  high in every state except IDLE.
- `gain_owner`  out  1  index of the port being served; valid while busy.
- `gain_timeout`  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
Request latching:
- `reqN_en` sets `pendN` and captures the words into `bufN`.
- A new pulse while `pendN` is already set overwrites `bufN`. The latest request wins and only one completion is reported.
- A pulse arriving while port N is being served sets `pendN` again for a later grant. It never disturbs the `gset_dac*` outputs in flight.

Arbitration (in IDLE):
- If exactly one `pend` flag is set, grant that port.
- If both are set, grant the port that did not win the last grant. After reset the last winner is port 1, so port 0 is favoured first.
- On grant: clear that port's `pend`, copy its `buf` into `gset_dacA/B`, set `gain_owner`.

State machine:
- **IDLE** → LAUNCH on grant.
- **LAUNCH** (1 cycle): `gset_en`=1 → WAIT_CMPT. If `gset_adc_cmpt` is sampled here, go straight to SETTLE, or to DONE when `SETTLE_CYC`=0.
- **WAIT_CMPT**: a timeout counter starts at 0.
  - On `gset_adc_cmpt`: go to SETTLE, or to DONE when `SETTLE_CYC`=0.
  - When the counter reaches `TIMEOUT_CYC`-1 with no `gset_adc_cmpt`: set the error flag and `gain_timeout`, go to DONE.
- **SETTLE**: counts `SETTLE_CYC` cycles → DONE.
- **DONE** (1 cycle): pulse `reqN_done` for `gain_owner`, and `reqN_err` if the error flag is set; clear the error flag → IDLE.

Other rules:
- `gset_adc_cmpt` is ignored in IDLE, SETTLE and DONE.
- Counters are sized to hold `SETTLE_CYC` and `TIMEOUT_CYC`. They never wrap: they saturate in their terminal state.

## Timing
- Reset values:
  - all outputs 0, including `gset_dacA/B`, `gain_owner` and `gain_timeout`;
  - internally: `pend0/1`=0, state=IDLE, last winner=1.
- Reset asserted mid-operation clears everything above within the same clock edge. No done pulse is emitted for the aborted request.
- Latency, with `req0_en` at cycle t while idle:
  - `pend0` set at t+1;
  - LAUNCH at t+2 (`gset_en`=1, `gset_dac*` valid);
  - if `gset_adc_cmpt` arrives at cycle c, DONE occurs at c+1+`SETTLE_CYC`.
- Back-to-back: DONE is followed by IDLE, so the next LAUNCH is no earlier than DONE+2.
- Simultaneous events:
  - Both `req*_en` pulse in the same cycle: both are latched and served in round-robin order.
  - `reqN_en` pulses in the same cycle as `reqN_done`: the new request is latched and served.

## Test plan
- Single host write, `SETTLE_CYC`=4: `req0_en` with A=0x1234, B=0xABCD at t, `gset_adc_cmpt` at t+10 → `gset_en` at t+2 with those words, `req0_done` at t+15, `req0_err`=0.
- Both requesters pulse at the same cycle from reset → port 0 launched first, then port 1. Repeat with both pending after a port-0 grant → port 1 served next.
- Overwrite: `req1_en` with 0x10 then 0x20 while a port-0 write is busy → one port-1 launch carrying 0x20, one `req1_done`.
- Timeout, `TIMEOUT_CYC`=8 with `gset_adc_cmpt` never asserted → DONE 8 cycles after WAIT_CMPT entry, `req0_done`=`req0_err`=1, `gain_timeout` stays 1 until reset.
- Reset low during SETTLE → next cycle all outputs 0, no done pulse. A new `req0_en` after release → normal launch at +2.
- `SETTLE_CYC`=0 with `gset_adc_cmpt` in the LAUNCH cycle → DONE on the following cycle, `req0_done` pulsed once.
